// File: rtl/generador_tlp_if.sv
// Bus between the TLP traffic generator and its controller: burst launch,
// per-FIFO write ports with almost_full backpressure, and the counter read port.
interface generador_tlp_if #(
    parameter int DATA_WIDTH = 10,
    parameter int CNT_WIDTH  = 5
) ();
    // Handshakes: start and request are single-cycle strobes sampled on the rising
    // edge; almost_full acts as an inverted ready, checked the cycle before wr rises;
    // wr and count_valid are registered qualifiers for data_out and count.
    logic                  start;
    logic [1:0]            chan;
    logic [CNT_WIDTH-1:0]  len;
    logic [DATA_WIDTH-3:0] seed;
    logic                  almost_full0;
    logic                  almost_full1;
    logic                  almost_full2;
    logic                  almost_full3;
    logic                  wr0;
    logic                  wr1;
    logic                  wr2;
    logic                  wr3;
    logic [DATA_WIDTH-1:0] data_out0;
    logic [DATA_WIDTH-1:0] data_out1;
    logic [DATA_WIDTH-1:0] data_out2;
    logic [DATA_WIDTH-1:0] data_out3;
    logic                  busy;
    logic                  done;
    logic                  request;
    logic [1:0]            idx;
    logic [CNT_WIDTH-1:0]  count;
    logic                  count_valid;

    modport master (
        output start, chan, len, seed,
        output almost_full0, almost_full1, almost_full2, almost_full3,
        output request, idx,
        input  wr0, wr1, wr2, wr3,
        input  data_out0, data_out1, data_out2, data_out3,
        input  busy, done, count, count_valid
    );

    modport slave (
        input  start, chan, len, seed,
        input  almost_full0, almost_full1, almost_full2, almost_full3,
        input  request, idx,
        output wr0, wr1, wr2, wr3,
        output data_out0, data_out1, data_out2, data_out3,
        output busy, done, count, count_valid
    );
endinterface

// File: rtl/generador_tlp.sv
// Burst word generator feeding four input FIFOs, with per-channel saturating
// write counters readable through a request/idx strobe.
module generador_tlp #(
    parameter int DATA_WIDTH = 10,
    parameter int CNT_WIDTH  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    generador_tlp_if.slave    bus,
    output logic [1:0]        o_state
);
    localparam int PW = DATA_WIDTH - 2;
    localparam logic [PW-1:0]        PAY_ONE = PW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                          r_state;
    logic [1:0]                      r_chan;
    logic [CNT_WIDTH-1:0]            r_rem;
    logic [PW-1:0]                   r_payload;
    logic [1:0]                      r_dest;
    logic [3:0]                      r_wr;
    logic [3:0][DATA_WIDTH-1:0]      r_data;
    logic                            r_busy;
    logic                            r_done;
    logic [3:0][CNT_WIDTH-1:0]       r_cnt;
    logic [CNT_WIDTH-1:0]            r_count;
    logic                            r_count_valid;

    state_t                          w_state_n;
    logic [1:0]                      w_chan_n;
    logic [CNT_WIDTH-1:0]            w_rem_n;
    logic [PW-1:0]                   w_payload_n;
    logic [1:0]                      w_dest_n;
    logic [3:0]                      w_wr_n;
    logic [3:0][DATA_WIDTH-1:0]      w_data_n;
    logic [3:0]                      w_af;
    logic                            w_af_sel;

    assign w_af     = {bus.almost_full3, bus.almost_full2, bus.almost_full1, bus.almost_full0};
    assign w_af_sel = w_af[r_chan];

    always_comb begin
        w_state_n   = r_state;
        w_chan_n    = r_chan;
        w_rem_n     = r_rem;
        w_payload_n = r_payload;
        w_dest_n    = r_dest;
        w_wr_n      = '0;
        w_data_n    = r_data;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_chan_n    = bus.chan;
                    w_rem_n     = bus.len;
                    w_payload_n = bus.seed;
                    w_dest_n    = 2'd0;
                    w_state_n   = (bus.len == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                // A stall leaves every register untouched so the word is retried.
                if (!w_af_sel) begin
                    w_wr_n[r_chan]   = 1'b1;
                    w_data_n[r_chan] = {r_dest, r_payload};
                    w_payload_n      = r_payload + PAY_ONE;
                    w_dest_n         = r_dest + 2'd1;
                    w_rem_n          = r_rem - CNT_ONE;
                    if (r_rem <= CNT_ONE) begin
                        w_state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_chan    <= '0;
            r_rem     <= '0;
            r_payload <= '0;
            r_dest    <= '0;
            r_wr      <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_chan    <= w_chan_n;
            r_rem     <= w_rem_n;
            r_payload <= w_payload_n;
            r_dest    <= w_dest_n;
            r_wr      <= w_wr_n;
            r_data    <= w_data_n;
            r_busy    <= (w_state_n == ST_SEND);
            r_done    <= (w_state_n == ST_DONE);
        end
    end

    // Counters follow the registered strobes, so a same-cycle read sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (r_wr[c] && (r_cnt[c] != CNT_MAX)) begin
                    r_cnt[c] <= r_cnt[c] + CNT_ONE;
                end
            end
            r_count_valid <= bus.request;
            if (bus.request) begin
                r_count <= r_cnt[bus.idx];
            end
        end
    end

    assign bus.wr0         = r_wr[0];
    assign bus.wr1         = r_wr[1];
    assign bus.wr2         = r_wr[2];
    assign bus.wr3         = r_wr[3];
    assign bus.data_out0   = r_data[0];
    assign bus.data_out1   = r_data[1];
    assign bus.data_out2   = r_data[2];
    assign bus.data_out3   = r_data[3];
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.count       = r_count;
    assign bus.count_valid = r_count_valid;
    assign o_state         = r_state;

endmodule
